pipelined_adder: RTL
====================

// Module: pipelined_adder
// PURPOSE
//  Parametrised successor to the single-lane combinational Adder: LANES independent WIDTH-bit lanes,
//  per-transaction op (add / sub / signed-saturating add), STAGES-deep pipeline and valid/ready on both sides.
//  Sits between the tb_interface-driven test and the scoreboard; final-stage outputs are registered.
// PARAMETERS
//  WIDTH   8  operand/result width per lane, in bits (>=2)
//  LANES   4  number of parallel lanes sharing one handshake
//  STAGES  2  pipeline depth = latency in cycles (>=1)
//  CNT_W  16  width of the completed-transaction counter
// PORTS
//  clk        in   1            single clock; all state updates on the rising edge
//  rst        in   1            synchronous reset, active-high
//  in_valid   in   1            operand beat valid
//  in_ready   out  1            block accepts a beat this cycle
//  in_op      in   2            op_e: ADD=0, SUB=1, ADDS=2 (signed saturating); 3 = reserved, treated as ADD
//  in_a       in   LANES*WIDTH  operand a; lane i is bits [i*WIDTH +: WIDTH]
//  in_b       in   LANES*WIDTH  operand b; same packing as in_a
//  out_valid  out  1            result beat valid
//  out_ready  in   1            downstream accepts the result
//  out_sum    out  LANES*WIDTH  per-lane result
//  out_carry  out  LANES        ADD: carry-out; SUB: borrow (a<b unsigned); ADDS: 0
//  out_ovf    out  LANES        signed overflow; ADDS: 1 when the result was clamped
//  done_cnt   out  CNT_W        count of beats accepted at the output (out_valid && out_ready)
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge): all stage valids=0, out_valid=0, out_sum=0, out_carry=0, out_ovf=0,
//    done_cnt=0. Reset wins over every other event in the same cycle. In-flight beats are dropped.
//  - Advance enable: adv = !out_valid || out_ready. in_ready = adv (combinational, no registered state).
//  - Accept when in_valid && in_ready. When adv=1 every stage shifts by one; a stage with valid=0 is a bubble.
//    When adv=0 every stage, including the output registers, holds its value.
//  - Latency: a beat accepted at edge N appears on out_valid/out_sum after edge N+STAGES-1,
//    i.e. STAGES cycles after in_valid is sampled, provided no stall occurs.
//  - Throughput: one beat per cycle while out_ready=1. Bubbles are not collapsed under stall
//    (global stall; by design).
//  - The result is computed in stage 0 and carried through the remaining STAGES-1 register stages unchanged.
//  - ADD: {carry,sum} = a + b, computed at WIDTH+1 bits. ovf = (a[msb]==b[msb]) && (sum[msb]!=a[msb]).
//  - SUB: sum = a - b, computed mod 2^WIDTH. carry = borrow. ovf = (a[msb]!=b[msb]) && (sum[msb]!=a[msb]).
//  - ADDS: on positive overflow sum = 0111..1; on negative overflow sum = 1000..0; ovf=1; otherwise plain sum.
//  - Lanes are fully independent; no carry propagates between lanes.
//  - out_sum, out_carry and out_ovf are stable while out_valid && !out_ready (AXI-style hold rule).
//  - done_cnt increments on each out_valid && out_ready and wraps from 2^CNT_W-1 to 0.
//  - When accept and output handshake happen in the same cycle, the pipeline shifts and the count increments.
//  - in_valid may be asserted or dropped at any time; a beat that is not accepted has no effect.
// STRUCTURE
//  - adder_pkg: typedef enum logic [1:0] op_e {ADD, SUB, ADDS, RSVD}; function sat_add(); lane-slice macro.
//  - One sub-module, adder_lane: combinational a/b/op -> sum/carry/ovf for one lane, instantiated LANES times.
//  - The pipeline stage array and done_cnt live in pipelined_adder.
//  - The tb_interface successor gains clk, rst and the handshake signals.
// TESTING
//  - Reset mid-stream: 3 beats in flight, rst=1 for 1 cycle -> out_valid=0, done_cnt=0; no stale beat emerges afterwards.
//  - ADD, WIDTH=8: a=0xFF, b=0x01 -> sum=0x00, carry=1, ovf=0; a=0x7F, b=0x01 -> sum=0x80, ovf=1. Latency = STAGES.
//  - SUB/ADDS: SUB a=0x00, b=0x01 -> sum=0xFF, carry=1. ADDS a=0x70, b=0x20 -> 0x7F, ovf=1.
//    ADDS a=0x80, b=0xFF -> 0x80, ovf=1.
//  - Backpressure: stream of 8 beats with out_ready toggling 1,0,0,1... -> no loss or duplication;
//    outputs hold while stalled; in_ready=0 exactly while out_valid && !out_ready.
//  - Lane independence: LANES=4, lane 2 overflows while the others do not -> only out_ovf[2]=1.
//  - Counter wrap: CNT_W=4, 17 completed beats -> done_cnt=1.

Source files
------------

// File: rtl/adder_pkg.sv
// adder_pkg: op encoding, saturation detect helper and lane slicing shared by pipelined_adder
`define LANE_SLICE(i, w) (i)*(w) +: (w)
package adder_pkg;
  typedef enum logic [1:0] {ADD, SUB, ADDS, RSVD} op_e;
  function automatic logic [1:0] sat_add(input logic a_msb, input logic b_msb, input logic s_msb);
    return {!a_msb && !b_msb && s_msb, a_msb && b_msb && !s_msb};
  endfunction
endpackage

// File: rtl/adder_lane.sv
// adder_lane: combinational add/sub/saturating-add for one lane
module adder_lane import adder_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf
);
  localparam int MSB = WIDTH - 1;
  logic [WIDTH:0] add_r, sub_r;
  logic [1:0] sat;
  always_comb begin
    add_r = {1'b0, a} + {1'b0, b};
    sub_r = {1'b0, a} - {1'b0, b};
    sat = sat_add(a[MSB], b[MSB], add_r[MSB]);
    sum = op == SUB ? sub_r[MSB:0] :
          op == ADDS && sat[1] ? {1'b0, {MSB{1'b1}}} :
          op == ADDS && sat[0] ? {1'b1, {MSB{1'b0}}} : add_r[MSB:0];
    carry = op == SUB ? sub_r[WIDTH] : op == ADDS ? 1'b0 : add_r[WIDTH];
    ovf = op == SUB ? (a[MSB] != b[MSB]) && (sub_r[MSB] != a[MSB])
                    : (a[MSB] == b[MSB]) && (add_r[MSB] != a[MSB]);
  end
endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: multi-lane add/sub/sat-add with a globally stalled valid/ready pipeline
module pipelined_adder import adder_pkg::*; #(
  parameter int WIDTH  = 8,
  parameter int LANES  = 4,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_op,
  input  logic [LANES*WIDTH-1:0] in_a,
  input  logic [LANES*WIDTH-1:0] in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_sum,
  output logic [LANES-1:0]       out_carry,
  output logic [LANES-1:0]       out_ovf,
  output logic [CNT_W-1:0]       done_cnt
);
  localparam int DW = LANES * WIDTH;
  logic adv;
  logic [DW-1:0] sum_c;
  logic [LANES-1:0] carry_c, ovf_c;
  logic [STAGES-1:0] vld;
  logic [DW-1:0] sum_q [STAGES];
  logic [LANES-1:0] carry_q [STAGES];
  logic [LANES-1:0] ovf_q [STAGES];
  assign adv = !vld[STAGES-1] || out_ready;
  assign in_ready = adv;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    adder_lane #(.WIDTH(WIDTH)) u_lane (
      .a(in_a[`LANE_SLICE(i, WIDTH)]),
      .b(in_b[`LANE_SLICE(i, WIDTH)]),
      .op(op_e'(in_op)),
      .sum(sum_c[`LANE_SLICE(i, WIDTH)]),
      .carry(carry_c[i]),
      .ovf(ovf_c[i])
    );
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      done_cnt <= '0;
      for (int s = 0; s < STAGES; s++) begin
        sum_q[s] <= '0;
        carry_q[s] <= '0;
        ovf_q[s] <= '0;
      end
    end else begin
      if (out_valid && out_ready) done_cnt <= done_cnt + 1'b1;
      if (adv) begin
        vld[0] <= in_valid;
        sum_q[0] <= sum_c;
        carry_q[0] <= carry_c;
        ovf_q[0] <= ovf_c;
        for (int s = 1; s < STAGES; s++) begin
          vld[s] <= vld[s-1];
          sum_q[s] <= sum_q[s-1];
          carry_q[s] <= carry_q[s-1];
          ovf_q[s] <= ovf_q[s-1];
        end
      end
    end
  end
  assign out_valid = vld[STAGES-1];
  assign out_sum = sum_q[STAGES-1];
  assign out_carry = carry_q[STAGES-1];
  assign out_ovf = ovf_q[STAGES-1];
endmodule
